// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle controller: state, error and instruction-kind encodings,
// MIPS opcode/funct values and datapath select values.
package multi_cycle_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'b00,
    ERR_ILLEGAL    = 2'b01,
    ERR_IM_TIMEOUT = 2'b10,
    ERR_DM_TIMEOUT = 2'b11
  } err_t;

  typedef enum logic [3:0] {
    K_NOP     = 4'd0,
    K_ADDU    = 4'd1,
    K_SUBU    = 4'd2,
    K_LUI     = 4'd3,
    K_ORI     = 4'd4,
    K_LW      = 4'd5,
    K_SW      = 4'd6,
    K_BEQ     = 4'd7,
    K_ILLEGAL = 4'd8
  } kind_t;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] EXT_UNSIGNED = 2'b00;
  localparam logic [1:0] EXT_SIGNED   = 2'b01;
  localparam logic [1:0] EXT_PAD      = 2'b10;

  localparam logic [1:0] NPC_DISABLED = 2'b00;
  localparam logic [1:0] NPC_BEQ      = 2'b01;

  typedef struct packed {
    logic       rfWriteAddr;
    logic       rfWriteData;
    logic       aluNum2;
    logic [1:0] aluOp;
    logic [1:0] extMode;
  } sel_t;

  function automatic logic [5:0] getOp(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] getFunct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/multi_cycle_control_instr_decoder.sv
// Combinational instruction classifier: maps an instruction word to its kind and the
// datapath mux/op selects that kind needs while it executes.
module multi_cycle_control_instr_decoder
  import multi_cycle_control_pkg::*;
(
  input  logic [31:0] i_instr,
  output kind_t       o_kind,
  output sel_t        o_sel
);

  always_comb begin
    o_kind = K_ILLEGAL;
    o_sel  = '0;
    case (getOp(i_instr))
      OP_RTYPE: begin
        // The all-zero word is the canonical nop; other R-type words need a supported funct
        if (i_instr == 32'h0000_0000) begin
          o_kind = K_NOP;
        end else if (getFunct(i_instr) == FUNCT_ADDU) begin
          o_kind            = K_ADDU;
          o_sel.rfWriteAddr = 1'b1;
          o_sel.aluOp       = ALU_ADD;
        end else if (getFunct(i_instr) == FUNCT_SUBU) begin
          o_kind            = K_SUBU;
          o_sel.rfWriteAddr = 1'b1;
          o_sel.aluOp       = ALU_SUB;
        end
      end
      OP_LUI: begin
        o_kind        = K_LUI;
        o_sel.aluNum2 = 1'b1;
        o_sel.extMode = EXT_PAD;
        o_sel.aluOp   = ALU_OR;
      end
      OP_ORI: begin
        o_kind        = K_ORI;
        o_sel.aluNum2 = 1'b1;
        o_sel.extMode = EXT_UNSIGNED;
        o_sel.aluOp   = ALU_OR;
      end
      OP_LW: begin
        o_kind            = K_LW;
        o_sel.aluNum2     = 1'b1;
        o_sel.extMode     = EXT_SIGNED;
        o_sel.aluOp       = ALU_ADD;
        o_sel.rfWriteData = 1'b1;
      end
      OP_SW: begin
        o_kind        = K_SW;
        o_sel.aluNum2 = 1'b1;
        o_sel.extMode = EXT_SIGNED;
        o_sel.aluOp   = ALU_ADD;
      end
      OP_BEQ: begin
        o_kind = K_BEQ;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle Moore controller sequencing the PC/IM/RF/ALU/EXT/DM/NPC datapath with IM/DM handshakes.
// Optional perf counters are enabled by defining MULTI_CYCLE_CONTROL_PERF_CNT_EN.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir_instr,
  input  logic        alu_zero,
  input  logic        im_ack,
  input  logic        dm_ack,
  output logic        im_req,
  output logic        dm_req,
  output logic        cw_ir_enable,
  output logic        cw_pc_enable,
  output logic        cw_rf_write_enable,
  output logic        cw_dm_write_enable,
  output logic        cm_rf_write_addr,
  output logic        cm_rf_write_data,
  output logic        cm_alu_num2,
  output logic [1:0]  cw_alu_op,
  output logic [1:0]  cw_ext_mode,
  output logic [1:0]  cw_npc_jump_mode,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [2:0]  state_o
`ifdef MULTI_CYCLE_CONTROL_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_retired
`endif
);

  localparam logic [31:0] LP_WAIT_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_nextState;
  err_t        r_errCode;
  err_t        w_nextErr;
  kind_t       r_kind;
  kind_t       w_kind;
  sel_t        r_sel;
  sel_t        w_sel;
  logic [31:0] r_waitCnt;
  logic        w_waitExpired;
  logic        w_unused;

  // alu_zero is observation-only: the NPC resolves beq on its own
  assign w_unused = alu_zero;

  multi_cycle_control_instr_decoder u_decoder (
    .i_instr (ir_instr),
    .o_kind  (w_kind),
    .o_sel   (w_sel)
  );

  assign w_waitExpired = (TIMEOUT_CYCLES != 0) && (r_waitCnt == LP_WAIT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_errCode <= ERR_NONE;
      r_kind    <= K_NOP;
      r_sel     <= '0;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_errCode <= w_nextErr;
      if (r_state == S_DECODE) begin
        r_kind <= w_kind;
        r_sel  <= w_sel;
      end
      // Any state change restarts the wait count, so FETCH/MEM always start counting from zero
      if (w_nextState != r_state) begin
        r_waitCnt <= '0;
      end else if (r_state == S_FETCH || r_state == S_MEM) begin
        r_waitCnt <= r_waitCnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_nextState        = r_state;
    w_nextErr          = r_errCode;
    im_req             = 1'b0;
    dm_req             = 1'b0;
    cw_ir_enable       = 1'b0;
    cw_pc_enable       = 1'b0;
    cw_rf_write_enable = 1'b0;
    cw_dm_write_enable = 1'b0;
    cm_rf_write_addr   = 1'b0;
    cm_rf_write_data   = 1'b0;
    cm_alu_num2        = 1'b0;
    cw_alu_op          = ALU_ADD;
    cw_ext_mode        = EXT_UNSIGNED;
    cw_npc_jump_mode   = NPC_DISABLED;

    if (r_state inside {S_EXEC, S_MEM, S_WB}) begin
      cm_rf_write_addr = r_sel.rfWriteAddr;
      cm_rf_write_data = r_sel.rfWriteData;
      cm_alu_num2      = r_sel.aluNum2;
      cw_alu_op        = r_sel.aluOp;
      cw_ext_mode      = r_sel.extMode;
    end

    case (r_state)
      S_IDLE: w_nextState = S_FETCH;
      S_FETCH: begin
        im_req       = 1'b1;
        cw_ir_enable = im_ack;
        // An ack in the same cycle as the timeout still wins
        if (im_ack) begin
          w_nextState = S_DECODE;
        end else if (w_waitExpired) begin
          w_nextState = S_ERR;
          w_nextErr   = ERR_IM_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (w_kind)
          K_ILLEGAL: begin
            w_nextState = S_ERR;
            w_nextErr   = ERR_ILLEGAL;
          end
          K_NOP: begin
            cw_pc_enable = 1'b1;
            w_nextState  = S_FETCH;
          end
          default: w_nextState = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (r_kind)
          K_LW, K_SW: w_nextState = S_MEM;
          K_BEQ: begin
            cw_npc_jump_mode = NPC_BEQ;
            cw_pc_enable     = 1'b1;
            w_nextState      = S_FETCH;
          end
          default: w_nextState = S_WB;
        endcase
      end
      S_MEM: begin
        dm_req             = 1'b1;
        cw_dm_write_enable = (r_kind == K_SW);
        if (dm_ack) begin
          if (r_kind == K_LW) begin
            w_nextState = S_WB;
          end else begin
            cw_pc_enable = 1'b1;
            w_nextState  = S_FETCH;
          end
        end else if (w_waitExpired) begin
          w_nextState = S_ERR;
          w_nextErr   = ERR_DM_TIMEOUT;
        end
      end
      S_WB: begin
        cw_rf_write_enable = 1'b1;
        cw_pc_enable       = 1'b1;
        w_nextState        = S_FETCH;
      end
      S_ERR: w_nextState = S_ERR;
      default: w_nextState = S_IDLE;
    endcase
  end

  assign halted   = (r_state == S_ERR);
  assign err_code = r_errCode;
  assign state_o  = r_state;

`ifdef MULTI_CYCLE_CONTROL_PERF_CNT_EN
  logic [31:0] r_perfCycles;
  logic [31:0] r_perfRetired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perfCycles  <= '0;
      r_perfRetired <= '0;
    end else begin
      if (r_state != S_ERR) begin
        r_perfCycles <= r_perfCycles + 32'd1;
      end
      if (cw_pc_enable) begin
        r_perfRetired <= r_perfRetired + 32'd1;
      end
    end
  end

  assign perf_cycles  = r_perfCycles;
  assign perf_retired = r_perfRetired;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: a driver issues instructions with random handshake
// delays and queues the expected retire/halt record; a negedge monitor pops and compares.
module tb_multi_cycle_control;

  localparam int TIMEOUT = 4;

  localparam int T_NOP  = 0;
  localparam int T_ADDU = 1;
  localparam int T_SUBU = 2;
  localparam int T_LUI  = 3;
  localparam int T_ORI  = 4;
  localparam int T_LW   = 5;
  localparam int T_SW   = 6;
  localparam int T_BEQ  = 7;
  localparam int T_ILL  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ir_instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        im_ack = 1'b0;
  logic        dm_ack = 1'b0;
  logic        im_req, dm_req, cw_ir_enable, cw_pc_enable, cw_rf_write_enable, cw_dm_write_enable;
  logic        cm_rf_write_addr, cm_rf_write_data, cm_alu_num2, halted;
  logic [1:0]  cw_alu_op, cw_ext_mode, cw_npc_jump_mode, err_code;
  logic [2:0]  state_o;
`ifdef MULTI_CYCLE_CONTROL_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_retired;
`endif

  multi_cycle_control #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .ir_instr           (ir_instr),
    .alu_zero           (alu_zero),
    .im_ack             (im_ack),
    .dm_ack             (dm_ack),
    .im_req             (im_req),
    .dm_req             (dm_req),
    .cw_ir_enable       (cw_ir_enable),
    .cw_pc_enable       (cw_pc_enable),
    .cw_rf_write_enable (cw_rf_write_enable),
    .cw_dm_write_enable (cw_dm_write_enable),
    .cm_rf_write_addr   (cm_rf_write_addr),
    .cm_rf_write_data   (cm_rf_write_data),
    .cm_alu_num2        (cm_alu_num2),
    .cw_alu_op          (cw_alu_op),
    .cw_ext_mode        (cw_ext_mode),
    .cw_npc_jump_mode   (cw_npc_jump_mode),
    .halted             (halted),
    .err_code           (err_code),
    .state_o            (state_o)
`ifdef MULTI_CYCLE_CONTROL_PERF_CNT_EN
    ,
    .perf_cycles        (perf_cycles),
    .perf_retired       (perf_retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          isErr;
    logic [1:0]  err;
    logic [2:0]  st;
    int          lat;
    int          imCyc;
    int          dmCyc;
    int          dmWeCyc;
    int          irPulses;
    logic [11:0] outs;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [11:0] packOuts(input bit rfwe, input bit dmwe, input bit dmreq, input bit wa,
                                           input bit wd, input bit num2, input logic [1:0] op,
                                           input logic [1:0] ext, input logic [1:0] jump);
    return {rfwe, dmwe, dmreq, wa, wd, num2, op, ext, jump};
  endfunction

  function automatic logic [11:0] outVec();
    return {cw_rf_write_enable, cw_dm_write_enable, dm_req, cm_rf_write_addr, cm_rf_write_data,
            cm_alu_num2, cw_alu_op, cw_ext_mode, cw_npc_jump_mode};
  endfunction

  function automatic logic [31:0] allOuts();
    return 32'({im_req, dm_req, cw_ir_enable, cw_pc_enable, cw_rf_write_enable, cw_dm_write_enable,
                cm_rf_write_addr, cm_rf_write_data, cm_alu_num2, cw_alu_op, cw_ext_mode,
                cw_npc_jump_mode, halted, err_code, state_o});
  endfunction

  function automatic logic [31:0] genInstr(input int kind);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] w;
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    case (kind)
      T_NOP:  w = 32'h0;
      T_ADDU: w = {6'h00, rs, rt, rd, 5'h00, 6'h21};
      T_SUBU: w = {6'h00, rs, rt, rd, 5'h00, 6'h23};
      T_LUI:  w = {6'h0F, 5'h00, rt, imm};
      T_ORI:  w = {6'h0D, rs, rt, imm};
      T_LW:   w = {6'h23, rs, rt, imm};
      T_SW:   w = {6'h2B, rs, rt, imm};
      T_BEQ:  w = {6'h04, rs, rt, imm};
      default: begin
        case ($urandom_range(0, 3))
          0:       w = {6'h3F, rs, rt, imm};
          1:       w = {6'h08, rs, rt, imm};
          2:       w = {6'h02, rs, rt, imm};
          default: w = {6'h00, rs, rt, rd, 5'h00, 6'h20};
        endcase
      end
    endcase
    return w;
  endfunction

  // Reference model: expected retire (or halt) record from kind and handshake delays.
  // imD/dmD = wait cycles before ack; a value >= TIMEOUT means the ack never comes in time.
  function automatic exp_t model(input int kind, input int imD, input int dmD);
    exp_t e;
    int   fetch;
    int   mem;
    e.isErr = 1'b0; e.err = 2'b00; e.st = 3'd0; e.lat = 0;
    e.imCyc = imD + 1; e.dmCyc = 0; e.dmWeCyc = 0; e.irPulses = 1; e.outs = '0;
    fetch = imD + 1;
    mem   = (dmD >= TIMEOUT) ? TIMEOUT : dmD + 1;
    case (kind)
      T_NOP: e.name = "nop";   T_ADDU: e.name = "addu"; T_SUBU: e.name = "subu";
      T_LUI: e.name = "lui";   T_ORI:  e.name = "ori";  T_LW:   e.name = "lw";
      T_SW:  e.name = "sw";    T_BEQ:  e.name = "beq";  default: e.name = "illegal";
    endcase
    if (imD >= TIMEOUT) begin
      e.isErr = 1'b1; e.err = 2'b10; e.st = 3'd6; e.lat = TIMEOUT;
      e.imCyc = TIMEOUT; e.irPulses = 0;
      e.name = {e.name, "/im-timeout"};
      return e;
    end
    case (kind)
      T_NOP:  begin e.st = 3'd2; e.lat = fetch + 1; end
      T_ADDU: begin e.st = 3'd5; e.lat = fetch + 3; e.outs = packOuts(1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00); end
      T_SUBU: begin e.st = 3'd5; e.lat = fetch + 3; e.outs = packOuts(1, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b00); end
      T_LUI:  begin e.st = 3'd5; e.lat = fetch + 3; e.outs = packOuts(1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00); end
      T_ORI:  begin e.st = 3'd5; e.lat = fetch + 3; e.outs = packOuts(1, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00); end
      T_BEQ:  begin e.st = 3'd3; e.lat = fetch + 2; e.outs = packOuts(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01); end
      T_LW, T_SW: begin
        e.dmCyc = mem;
        if (kind == T_SW) e.dmWeCyc = mem;
        if (dmD >= TIMEOUT) begin
          e.isErr = 1'b1; e.err = 2'b11; e.st = 3'd6; e.lat = fetch + 2 + TIMEOUT;
          e.name = {e.name, "/dm-timeout"};
        end else if (kind == T_LW) begin
          e.st = 3'd5; e.lat = fetch + 2 + mem + 1;
          e.outs = packOuts(1, 0, 0, 0, 1, 1, 2'b00, 2'b01, 2'b00);
        end else begin
          e.st = 3'd4; e.lat = fetch + 2 + mem;
          e.outs = packOuts(0, 1, 1, 0, 0, 1, 2'b00, 2'b01, 2'b00);
        end
      end
      default: begin e.isErr = 1'b1; e.err = 2'b01; e.st = 3'd6; e.lat = fetch + 1; end
    endcase
    return e;
  endfunction

  // Monitor: accumulates per-instruction activity and checks it on each retire or first halt cycle
  int   cyc, imCnt, dmCnt, dmWeCnt, irCnt, lat;
  bit   haltSeen;
  exp_t monExp;

  always @(negedge clk) begin
    if (!reset_n || state_o == 3'd0) begin
      cyc = 0; imCnt = 0; dmCnt = 0; dmWeCnt = 0; irCnt = 0; haltSeen = 0;
    end else begin
      imCnt   += int'(im_req);
      dmCnt   += int'(dm_req);
      dmWeCnt += int'(cw_dm_write_enable);
      irCnt   += int'(cw_ir_enable);
      if (cw_pc_enable || (halted && !haltSeen)) begin
        if (halted) haltSeen = 1;
        lat = halted ? cyc : cyc + 1;
        if (sbq.size() == 0) begin
          checkOutput("unexpected retire/halt", 32'(allOuts()), 32'h0);
        end else begin
          monExp = sbq.pop_front();
          checkOutput({monExp.name, " state"},      32'(state_o),     32'(monExp.st));
          checkOutput({monExp.name, " latency"},    32'(lat),         32'(monExp.lat));
          checkOutput({monExp.name, " im_req cyc"}, 32'(imCnt),       32'(monExp.imCyc));
          checkOutput({monExp.name, " dm_req cyc"}, 32'(dmCnt),       32'(monExp.dmCyc));
          checkOutput({monExp.name, " dm_we cyc"},  32'(dmWeCnt),     32'(monExp.dmWeCyc));
          checkOutput({monExp.name, " ir_en"},      32'(irCnt),       32'(monExp.irPulses));
          checkOutput({monExp.name, " selects"},    32'(outVec()),    32'(monExp.outs));
          checkOutput({monExp.name, " halted"},     32'(halted),      32'(monExp.isErr));
          checkOutput({monExp.name, " err_code"},   32'(err_code),    32'(monExp.err));
        end
        cyc = 0; imCnt = 0; dmCnt = 0; dmWeCnt = 0; irCnt = 0;
      end else if (!halted) begin
        cyc++;
      end
    end
  end

  // Driver: issues one instruction and answers req with ack after the chosen delay
  task automatic applyStimulus(input logic [31:0] instr, input int kind, input int imD, input int dmD);
    int imSeen, dmSeen;
    bit done;
    @(posedge clk); #1;
    ir_instr = instr;
    sbq.push_back(model(kind, imD, dmD));
    imSeen = 0; dmSeen = 0; done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c != 0) begin
        @(posedge clk); #1;
      end
      if (im_req) begin
        im_ack = (imSeen == imD);
        imSeen++;
      end else begin
        im_ack = ($urandom_range(0, 3) == 0);
      end
      if (dm_req) begin
        dm_ack = (dmSeen == dmD);
        dmSeen++;
      end else begin
        dm_ack = ($urandom_range(0, 3) == 0);
      end
      #1;
      if (cw_pc_enable || halted) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL instr 0x%08h completion: got none within 60 cycles, expected retire or halt", instr);
    end
  endtask

  task automatic holdErr();
    repeat (3) begin
      @(negedge clk);
      checkOutput("err hold {halted,pc_en,im_req,dm_req}", 32'({halted, cw_pc_enable, im_req, dm_req}), 32'h8);
    end
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    im_ack  = 1'b0;
    dm_ack  = 1'b0;
    #1;
    sbq.delete();
    checkOutput("reset outputs", allOuts(), 32'h0);
    @(posedge clk); #1;
    checkOutput("reset held", allOuts(), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("idle after release", 32'(state_o), 32'h0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    doReset();

    applyStimulus(32'h34011234, T_ORI,  0, 0);
    applyStimulus(32'h00221821, T_ADDU, 3, 0);
    applyStimulus(32'h8C040000, T_LW,   0, 2);
    applyStimulus(32'hAC010004, T_SW,   1, 0);
    applyStimulus(32'h1000FFFF, T_BEQ,  0, 0);
    applyStimulus(32'h00000000, T_NOP,  0, 0);
    applyStimulus(32'h3C0FBEEF, T_LUI,  2, 0);
    applyStimulus(32'h00221823, T_SUBU, 0, 0);
    applyStimulus(32'hFC000000, T_ILL,  0, 0);
    holdErr();
    doReset();
    applyStimulus(32'h8C040000, T_LW,   0, 9);
    holdErr();
    doReset();
    applyStimulus(32'h8C040000, T_LW,   0, 3);
    applyStimulus(32'hAC010004, T_SW,   2, 9);
    holdErr();
    doReset();
    applyStimulus(32'h34011234, T_ORI,  9, 0);
    holdErr();
    doReset();
    applyStimulus(32'h34011234, T_ORI,  3, 0);

    // Reset while a store is waiting in MEM must drop the request and write enable at once
    @(posedge clk); #1;
    ir_instr = 32'hAC010004;
    dm_ack   = 1'b0;
    for (int c = 0; c < 20 && !dm_req; c++) begin
      im_ack = im_req;
      @(posedge clk); #1;
    end
    im_ack = 1'b0;
    checkOutput("sw in MEM {dm_req,dm_we}", 32'({dm_req, cw_dm_write_enable}), 32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset {dm_req,dm_we,state}", 32'({dm_req, cw_dm_write_enable, state_o}), 32'h0);
    doReset();

    for (int n = 0; n < 150; n++) begin
      int kind, imD, dmD;
      kind = $urandom_range(0, 8);
      if (kind == T_ILL && $urandom_range(0, 1) == 1) kind = T_ADDU;
      imD = ($urandom_range(0, 15) == 0) ? 9 : $urandom_range(0, 3);
      dmD = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 3);
      e = model(kind, imD, dmD);
      applyStimulus(genInstr(kind), kind, imD, dmD);
      if (e.isErr) begin
        holdErr();
        doReset();
      end
    end

    @(posedge clk); @(negedge clk); #1;
    checkOutput("scoreboard drained", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Moore-style FSM that sequences the existing PC/IM/RF/ALU/EXT/DM/NPC datapath over several cycles per instruction instead of one.
- Supports addu, subu, lui, ori, lw, sw, beq, nop.
- Adds req/ack handshakes to IM and DM, a one-cycle PC-enable pulse per retired instruction, and halt-on-illegal or halt-on-timeout.
- Sits between the instruction register output and the datapath control inputs.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for im_ack/dm_ack before entering S_ERR. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ir_instr  in  32  instruction register contents; stable from S_DECODE until the next fetch.
- alu_zero  in  1  ALU equal flag; used for debug only, since the NPC resolves beq itself.
- im_ack  in  1  IM data valid.
- dm_ack  in  1  DM access done.
- im_req  out  1  IM fetch request.
- dm_req  out  1  DM access request.
- cw_ir_enable  out  1  load IR.
- cw_pc_enable  out  1  advance PC from NPC.
- cw_rf_write_enable  out  1  RF write enable.
- cw_dm_write_enable  out  1  DM write enable.
- cm_rf_write_addr  out  1  0 = instr[20:16], 1 = instr[15:11].
- cm_rf_write_data  out  1  0 = ALU result, 1 = DM read data.
- cm_alu_num2  out  1  0 = RF read data 2, 1 = EXT result.
- cw_alu_op  out  2  00 = ADD, 01 = SUB, 10 = OR.
- cw_ext_mode  out  2  00 = unsigned, 01 = signed, 10 = pad (lui).
- cw_npc_jump_mode  out  2  00 = disabled, 01 = jump when equal.
- halted  out  1  FSM is in S_ERR.
- err_code  out  2  00 = none, 01 = illegal instruction, 10 = IM timeout, 11 = DM timeout.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- States:
  - S_IDLE = 0: the state held during reset.
  - S_FETCH = 1: im_req = 1. On im_ack: cw_ir_enable = 1 that cycle, then go to S_DECODE.
  - S_DECODE = 2: decode ir_instr opcode/funct into a registered kind.
    - Illegal instruction → S_ERR with err_code = 01.
    - nop → cw_pc_enable pulse, then S_FETCH.
    - All other instructions → S_EXEC.
  - S_EXEC = 3:
    - addu/subu/lui/ori → S_WB.
    - lw/sw → S_MEM.
    - beq: cw_npc_jump_mode = 01 and cw_pc_enable = 1 this cycle, then S_FETCH.
  - S_MEM = 4: dm_req = 1; cw_dm_write_enable = 1 while dm_req is high for sw.
    - On dm_ack, lw → S_WB.
    - On dm_ack, sw → cw_pc_enable pulse, then S_FETCH.
  - S_WB = 5: cw_rf_write_enable = 1 and cw_pc_enable = 1 for exactly one cycle, then S_FETCH.
  - S_ERR = 6: terminal; all enables and requests are 0; halted = 1. Left only by reset.
- Reset and IDLE:
  - Asserting reset_n low forces S_IDLE asynchronously; all outputs go to 0, including err_code and the timeout counter.
  - After reset_n rises, S_IDLE moves unconditionally to S_FETCH on the next edge.
- Mux and op selects hold their decoded per-kind values through S_EXEC, S_MEM and S_WB:
  - addu/subu: write_addr = 1, num2 = 0.
  - lui: num2 = 1, ext = 10, op = OR.
  - ori: num2 = 1, ext = 00, op = OR.
  - lw/sw: num2 = 1, ext = 01, op = ADD; lw write_data = 1.
  - beq: num2 = 0.
  - In S_IDLE, S_FETCH and S_ERR the selects are 0.
- Handshake:
  - An ack is sampled only while the corresponding req is high; an ack arriving with no req is ignored.
  - An ack in the first cycle of the wait state is accepted, giving zero wait cycles.
  - req deasserts in the cycle after the ack.
- Minimum latency:
  - 4 cycles: addu, subu, lui, ori, sw.
  - 5 cycles: lw.
  - 3 cycles: beq.
  - 2 cycles: nop.
- Timeout:
  - The wait counter clears on entry to S_FETCH or S_MEM and increments each cycle without an ack.
  - Reaching TIMEOUT_CYCLES → S_ERR with err_code 10 (IM) or 11 (DM).
  - An ack arriving in the same cycle as the timeout wins; no error is raised.
- cw_pc_enable is asserted exactly once per retired instruction. It never asserts in S_ERR and never for an illegal instruction.
- Reset mid-S_MEM drops dm_req and cw_dm_write_enable asynchronously.

Optional Feature:
- Macro: MULTI_CYCLE_CONTROL_PERF_CNT_EN.
- When defined, adds two outputs:
  - perf_cycles [31:0]: counts every clock with reset_n high and not in S_ERR.
  - perf_retired [31:0]: increments on each cw_pc_enable pulse.
- Both counters reset to 0 asynchronously and wrap modulo 2^32.
- When the macro is undefined, neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Shared package/header (mc-control.h) holds:
  - state encodings;
  - err_code values;
  - opcode/funct magic numbers and GET_OP/GET_FUNCT, reused from the existing instruction header;
  - ALU/EXT/NPC select values.
- One natural sub-module: instr_decoder, a combinational ir_instr → kind[3:0] mapping plus the per-kind mux selects. The FSM registers its output in S_DECODE.

Test Plan:
- ori 0x34011234 with im_ack in the first cycle → states 1,2,3,5,1. In S_WB: num2 = 1, ext = 00, op = 10, rf_we = 1, pc_en = 1. Retire takes 4 cycles.
- addu 0x00221821 with im_ack delayed 3 cycles → im_req held 4 cycles, then cw_ir_enable pulses once. In WB: write_addr = 1, op = 00.
- lw 0x8C040000 with dm_ack after 2 cycles → dm_req high 3 cycles with dm_we = 0; WB has write_data = 1. Then sw 0xAC010004 → dm_we = 1 while in MEM, no WB state, pc_en on the dm_ack cycle.
- beq 0x1000FFFF → npc_jump_mode = 01 and pc_en = 1 in S_EXEC; rf_we and dm_req stay 0. nop 0x00000000 → pc_en in S_DECODE.
- Illegal 0xFC000000 → S_ERR, halted = 1, err_code = 01, pc_en never asserted. Later pulse reset_n low → S_IDLE and all outputs 0.
- TIMEOUT_CYCLES = 4 with no dm_ack during lw → S_ERR, err_code = 11. Repeat with dm_ack on the 4th wait cycle → no error.
